// File: rtl/tick_sequencer_if.sv
// Handshake bundle between the generation-tick timer and its consumers.
// The timer sits on the slave modport, and the controller or bench sits on the master modport.
interface tick_sequencer_if #(
    parameter int W = 3
);
    logic         ena;
    logic         mode;
    logic         start;
    logic [W-1:0] tick_out;
    logic         tick_strobe;
    logic         wrap;
    logic         busy;

    modport master (
        output ena, mode, start,
        input  tick_out, tick_strobe, wrap, busy
    );

    modport slave (
        input  ena, mode, start,
        output tick_out, tick_strobe, wrap, busy
    );
endinterface

// File: rtl/tick_sequencer.sv
// Generation-tick timer for the life array. It counts 0..N_TICKS-1 once every PRESCALE enabled cycles.
// It runs free or as a one-shot pass, and it emits registered tick and wrap strobes.
module tick_sequencer #(
    parameter int N_TICKS  = 8,
    parameter int W        = $clog2(N_TICKS),
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    tick_sequencer_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    tick_q;
    logic [PW-1:0]   pre_cnt;
    logic            strobe_q;
    logic            wrap_q;
    logic            busy;
    logic            run;
    logic            last_pre;
    logic            last_tick;
    logic            step;

    // One-shot pass state. In free-run mode it falls back to IDLE.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.mode && bus.start) state_nxt = RUN;
            RUN: begin
                if (!bus.mode)
                    state_nxt = IDLE;
                else if (step && last_tick)
                    state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        run       = bus.ena && (!bus.mode || busy);
        last_pre  = (pre_cnt == PW'(PRESCALE - 1));
        last_tick = (tick_q == W'(N_TICKS - 1));
        step      = run && last_pre;
    end

    // The tick wraps explicitly at N_TICKS-1, so a non-power-of-two count never passes through an illegal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q   <= '0;
            pre_cnt  <= '0;
            strobe_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            strobe_q <= step;
            wrap_q   <= step && last_tick;
            if (run)
                pre_cnt <= last_pre ? '0 : pre_cnt + 1'b1;
            if (step)
                tick_q <= last_tick ? '0 : tick_q + 1'b1;
        end
    end

    assign bus.tick_out    = tick_q;
    assign bus.tick_strobe = strobe_q;
    assign bus.wrap        = wrap_q;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer. Three configurations share one stimulus stream: (8,1), (5,3) and (4,2).
// A phase-counter model is checked every cycle, and directed literal checks pin the model.
module tb_tick_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic mode;
    logic start;
    bit   chk_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_sequencer_if #(.W(3)) if0 ();
    tick_sequencer_if #(.W(3)) if1 ();
    tick_sequencer_if #(.W(2)) if2 ();

    assign if0.ena = ena;  assign if0.mode = mode;  assign if0.start = start;
    assign if1.ena = ena;  assign if1.mode = mode;  assign if1.start = start;
    assign if2.ena = ena;  assign if2.mode = mode;  assign if2.start = start;

    tick_sequencer #(.N_TICKS(8), .W(3), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    tick_sequencer #(.N_TICKS(5), .W(3), .PRESCALE(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    tick_sequencer #(.N_TICKS(4), .W(2), .PRESCALE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int nt(int k);
        case (k)
            0:       return 8;
            1:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int ps(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model. Each pass is a position in 0..N*P-1 of enabled cycles.
    // The tick index is position / P, and a step happens when the position reaches a multiple of P.
    int phase  [3];
    bit m_busy [3];
    bit m_strb [3];
    bit m_wrap [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int len;
            int nxt;
            bit run_m;
            bit stepped;
            bit wrapped;
            if (rst) begin
                phase[k]  = 0;
                m_busy[k] = 1'b0;
                m_strb[k] = 1'b0;
                m_wrap[k] = 1'b0;
            end else begin
                len     = nt(k) * ps(k);
                run_m   = ena && (!mode || m_busy[k]);
                stepped = 1'b0;
                wrapped = 1'b0;
                if (run_m) begin
                    nxt      = (phase[k] + 1) % len;
                    stepped  = ((phase[k] + 1) % ps(k)) == 0;
                    wrapped  = (nxt == 0);
                    phase[k] = nxt;
                end
                m_strb[k] = stepped;
                m_wrap[k] = wrapped;
                if (!m_busy[k])   m_busy[k] = mode && start;
                else if (!mode)   m_busy[k] = 1'b0;
                else if (wrapped) m_busy[k] = start;
            end
        end
    end

    task automatic cmp_inst(int k, int t, int s, int w, int b);
        check($sformatf("i%0d_tick", k),   t, phase[k] / ps(k));
        check($sformatf("i%0d_strobe", k), s, int'(m_strb[k]));
        check($sformatf("i%0d_wrap", k),   w, int'(m_wrap[k]));
        check($sformatf("i%0d_busy", k),   b, int'(m_busy[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, int'(if0.tick_out), int'(if0.tick_strobe), int'(if0.wrap), int'(if0.busy));
            cmp_inst(1, int'(if1.tick_out), int'(if1.tick_strobe), int'(if1.wrap), int'(if1.busy));
            cmp_inst(2, int'(if2.tick_out), int'(if2.tick_strobe), int'(if2.wrap), int'(if2.busy));
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; mode = 1'b0; start = 1'b0;
        edge1();
        chk_en = 1'b1;
        edge1();
        check("rst_tick",   int'(if0.tick_out),    0);
        check("rst_strobe", int'(if0.tick_strobe), 0);
        check("rst_wrap",   int'(if0.wrap),        0);
        check("rst_busy",   int'(if0.busy),        0);

        // Free-run: the legacy 8-tick sequence and the 5x3 prescaled sequence
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            if (e <= 9) begin
                check("fr8_tick",   int'(if0.tick_out),    e % 8);
                check("fr8_wrap",   int'(if0.wrap),        int'(e == 8));
                check("fr8_strobe", int'(if0.tick_strobe), 1);
            end
            check("fr5_tick",   int'(if1.tick_out),    (e / 3) % 5);
            check("fr5_wrap",   int'(if1.wrap),        int'(e == 15));
            check("fr5_strobe", int'(if1.tick_strobe), int'(e % 3 == 0));
        end

        // Pausing mid-hold at tick 2 delays the 2->3 step by exactly the pause length
        rst = 1'b1; edge1(); rst = 1'b0;
        repeat (7) edge1();
        check("pause_pre", int'(if1.tick_out), 2);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge1();
            check("pause_tick",   int'(if1.tick_out),    2);
            check("pause_strobe", int'(if1.tick_strobe), 0);
        end
        ena = 1'b1;
        edge1();
        check("resume_hold", int'(if1.tick_out), 2);
        edge1();
        check("resume_step",   int'(if1.tick_out),    3);
        check("resume_strobe", int'(if1.tick_strobe), 1);

        // One-shot 4x2 pass, with a second start mid-pass that is ignored
        rst = 1'b1; mode = 1'b1; edge1(); rst = 1'b0;
        edge1();
        check("os_idle_busy", int'(if2.busy), 0);
        start = 1'b1; edge1(); start = 1'b0;
        check("os_start_busy", int'(if2.busy),     1);
        check("os_start_tick", int'(if2.tick_out), 0);
        for (int j = 1; j <= 8; j++) begin
            start = (j == 3);
            edge1();
            check("os_tick", int'(if2.tick_out), (j / 2) % 4);
            check("os_busy", int'(if2.busy),     int'(j < 8));
            check("os_wrap", int'(if2.wrap),     int'(j == 8));
        end
        start = 1'b0;

        // Start held through the final step edge gives a back-to-back pass
        start = 1'b1; edge1();
        for (int j = 1; j <= 8; j++) edge1();
        check("b2b_busy", int'(if2.busy),     1);
        check("b2b_wrap", int'(if2.wrap),     1);
        check("b2b_tick", int'(if2.tick_out), 0);
        start = 1'b0;
        edge1();
        edge1();
        check("b2b_next_tick", int'(if2.tick_out), 1);
        check("b2b_next_busy", int'(if2.busy),     1);
        repeat (6) edge1();
        check("b2b_end_busy", int'(if2.busy), 0);
        check("b2b_end_wrap", int'(if2.wrap), 1);

        // A start pulse while disabled is latched, but the count stays frozen
        ena = 1'b0; start = 1'b1; edge1(); start = 1'b0;
        check("dis_busy", int'(if2.busy), 1);
        for (int i = 0; i < 3; i++) begin
            edge1();
            check("dis_tick",   int'(if2.tick_out),    0);
            check("dis_strobe", int'(if2.tick_strobe), 0);
        end
        ena = 1'b1;

        // Reset mid-pass at tick 3 with pre_cnt 1
        repeat (7) edge1();
        check("mid_tick", int'(if2.tick_out), 3);
        check("mid_busy", int'(if2.busy),     1);
        rst = 1'b1; edge1();
        check("mrst_tick",   int'(if2.tick_out),    0);
        check("mrst_strobe", int'(if2.tick_strobe), 0);
        check("mrst_wrap",   int'(if2.wrap),        0);
        check("mrst_busy",   int'(if2.busy),        0);
        rst = 1'b0; mode = 1'b0;

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            ena   = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            edge1();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
Parametrised generation-tick timer for the life array. It is the successor to the fixed 3-bit, 8-tick wrap counter. It adds the following:
- an arbitrary tick count, including non-power-of-two values;
- a clock prescaler;
- an enable/pause input;
- a free-run or one-shot mode;
- single-cycle tick and wrap strobes.

The cell-update sequencer and display refresh consume tick_out and the strobes.

Parameters:
N_TICKS, 8, number of distinct ticks per generation; tick_out counts 0..N_TICKS-1; legal range >= 2.
W, $clog2(N_TICKS), width of tick_out; must satisfy 2**W >= N_TICKS.
PRESCALE, 1, enabled clock cycles per tick step; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset; overrides every other input.
ena  input  1  count enable; low freezes all counting state.
mode  input  1  0 = free-run; 1 = one-shot (single pass 0..N_TICKS-1..0 per start).
start  input  1  one-shot trigger, sampled each cycle; ignored in free-run mode.
tick_out  output  W  current tick index, registered.
tick_strobe  output  1  high for exactly the cycle in which tick_out holds a newly stepped value.
wrap  output  1  high for the cycle in which tick_out has just gone from N_TICKS-1 to 0.
busy  output  1  one-shot pass in progress; always 0 in free-run mode.

Behaviour:
- Reset (rst=1 at posedge): tick_out=0, internal prescale count pre_cnt=0, busy=0, tick_strobe=0, wrap=0. Takes priority over ena, start and mode.
- Run condition: run = ena & (mode==0 | busy).
- Prescaler: when run=1, pre_cnt advances 0..PRESCALE-1 and wraps. step = run & (pre_cnt==PRESCALE-1). With PRESCALE=1, step = run.
- Step: tick_out <= (tick_out==N_TICKS-1) ? 0 : tick_out+1. No intermediate value may ever exceed N_TICKS-1, including for non-power-of-two N_TICKS.
- Strobes are registered and aligned with the new value:
  - tick_strobe=1 in the cycle after each step edge, i.e. while the new tick_out is visible.
  - wrap=1 in that same cycle only when the new value is 0 via wrap-around.
  - Both are 0 otherwise.
- Legacy equivalence: with N_TICKS=8, PRESCALE=1, mode=0, ena=1, the first posedge after rst falls gives tick_out=1. The count then steps every cycle, 7 -> 0.
- ena=0: tick_out, pre_cnt and busy hold; no strobes; start is still latched (see below).
- One-shot mode, with busy treated as a registered state (IDLE = busy 0, RUN = busy 1):
  - IDLE & mode=1 & start=1 -> busy=1 at the next edge; this happens even when ena=0.
  - RUN: start is ignored, except as below.
  - The step that produces wrap clears busy at the same edge: busy falls in the same cycle wrap rises.
  - If start=1 coincides with that final step edge, busy stays 1 (back-to-back pass with no idle cycle).
  - A pass lasts exactly N_TICKS*PRESCALE enabled cycles and ends with tick_out=0 and pre_cnt=0.
- Mode changes are sampled every cycle with no reset of the count:
  - 0->1 mid-count: busy=0, so the count freezes at its current tick until start. The pass then runs from there to the next wrap.
  - 1->0 while busy: busy clears at the next edge and free-run continues from the current values.
- PRESCALE=1 needs no pre_cnt register; this is legal but not required.
- Outputs never go X after reset.

Test Plan:
1. N_TICKS=8, PRESCALE=1, mode=0, ena=1; rst high 2 cycles then low -> tick_out 1,2,...,7,0,1 on successive edges; wrap high only in the cycle showing 0; tick_strobe high every cycle.
2. N_TICKS=5, PRESCALE=3, mode=0 -> tick_out holds each value 3 cycles: 0,0,0,1,1,1,...,4,4,4,0. Value 5-7 never appears. Exactly one wrap pulse per 15 cycles.
3. N_TICKS=5, PRESCALE=3; ena toggled low 4 cycles mid-hold at tick 2 -> tick_out stays 2. The remaining prescale count resumes with no lost or extra cycles; the 2->3 step is delayed by exactly 4 cycles.
4. mode=1, N_TICKS=4, PRESCALE=2:
   - start pulse -> busy high for 8 cycles, tick_out 0,0,1,1,2,2,3,3,0;
   - busy falls with the wrap pulse;
   - a second start mid-pass has no effect.
5. mode=1, start held high on the final step edge -> busy stays 1 and a second pass begins with no idle cycle. With start pulsed while ena=0 -> busy=1 but tick_out frozen until ena rises.
6. rst asserted mid-pass at tick_out=3, busy=1, pre_cnt=1 -> next edge gives all outputs 0; wrap and tick_strobe are not asserted in that cycle.
